// File: rtl/relu_grad_gate_pkg.sv
// Shared types and helpers for the ReLU forward/backward datapath.
// Holds the default word width, the word type and the mask helper.
package relu_grad_gate_pkg;

  localparam int WIDTH_DEF = 20;
  localparam int DEPTH_DEF = 64;

  typedef logic [WIDTH_DEF-1:0] word_t;

  // Zero passes through the forward ReLU, so only a set sign bit clamps.
  function automatic logic relu_mask(input logic sign);
    return ~sign;
  endfunction

endpackage

// File: rtl/mask_fifo.sv
// One-bit-wide synchronous FIFO holding ReLU derivative bits.
// Ports: push/din, pop/dout, full, empty, count, synchronous flush.
module mask_fifo #(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        push,
  input  logic        din,
  input  logic        pop,
  output logic        dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/relu_grad_gate.sv
// Gates the backward gradient stream with forward ReLU derivative bits.
// Ports: fwd_* mask input, grad_* gradient input, gout_* gated output.
module relu_grad_gate
  import relu_grad_gate_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             fwd_valid,
  output logic             fwd_ready,
  input  logic [WIDTH-1:0] fwd_data,
  input  logic             grad_valid,
  output logic             grad_ready,
  input  logic [WIDTH-1:0] grad_in,
  output logic             gout_valid,
  input  logic             gout_ready,
  output logic [WIDTH-1:0] gout_data,
  output logic [AW:0]      mask_count
);

  logic full;
  logic empty;
  logic mask;
  logic push;
  logic pop;
  logic unused_low;

  // Only the sign bit of a forward sample matters.
  assign unused_low = ^fwd_data[WIDTH-2:0];

  assign fwd_ready  = !full;
  assign grad_ready = !empty && (!gout_valid || gout_ready);

  // Handshakes in a flush cycle complete but are discarded.
  assign push = fwd_valid && fwd_ready && !flush;
  assign pop  = grad_valid && grad_ready && !flush;

  mask_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .din   (relu_mask(fwd_data[WIDTH-1])),
    .pop   (pop),
    .dout  (mask),
    .full  (full),
    .empty (empty),
    .count (mask_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gout_valid <= 1'b0;
      gout_data  <= '0;
    end else if (flush) begin
      gout_valid <= 1'b0;
    end else if (pop) begin
      gout_valid <= 1'b1;
      gout_data  <= mask ? grad_in : '0;
    end else if (gout_ready) begin
      gout_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_relu_grad_gate.sv
// Self-checking bench for relu_grad_gate: vector table, directed
// corner sequences and random traffic against a queue-based model.
module tb_relu_grad_gate;
  import relu_grad_gate_pkg::*;

  localparam int W = 20;
  localparam int D = 64;

  logic         clk = 0;
  logic         rst_n = 0;
  logic         flush = 0;
  logic         fwd_valid = 0;
  logic         fwd_ready;
  logic [W-1:0] fwd_data = '0;
  logic         grad_valid = 0;
  logic         grad_ready;
  logic [W-1:0] grad_in = '0;
  logic         gout_valid;
  logic         gout_ready = 0;
  logic [W-1:0] gout_data;
  logic [6:0]   mask_count;

  relu_grad_gate #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .fwd_valid  (fwd_valid),
    .fwd_ready  (fwd_ready),
    .fwd_data   (fwd_data),
    .grad_valid (grad_valid),
    .grad_ready (grad_ready),
    .grad_in    (grad_in),
    .gout_valid (gout_valid),
    .gout_ready (gout_ready),
    .gout_data  (gout_data),
    .mask_count (mask_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: the stored masks are a plain queue; the output is one slot.
  bit           mq[$];
  bit           mv = 0;
  logic [W-1:0] md = '0;

  typedef struct {
    logic [W-1:0] fd;
    logic [W-1:0] gd;
    logic [W-1:0] exp;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mv = 0;
    md = '0;
  endtask

  // One cycle: drive, check against the model, advance the model.
  task automatic cyc(input bit fv, input logic [W-1:0] fd,
                     input bit gv, input logic [W-1:0] gd,
                     input bit gr, input bit fl);
    bit efr, egr, m;
    fwd_valid  = fv;
    fwd_data   = fd;
    grad_valid = gv;
    grad_in    = gd;
    gout_ready = gr;
    flush      = fl;
    #1;
    efr = (mq.size() != D);
    egr = (mq.size() != 0) && (!mv || gr);
    chk("fwd_ready", 32'(fwd_ready), 32'(efr));
    chk("grad_ready", 32'(grad_ready), 32'(egr));
    chk("mask_count", 32'(mask_count), 32'(mq.size()));
    chk("gout_valid", 32'(gout_valid), 32'(mv));
    if (mv) chk("gout_data", 32'(gout_data), 32'(md));
    if (fl) begin
      mq.delete();
      mv = 0;
    end else begin
      if (gv && egr) begin
        m  = mq.pop_front();
        mv = 1;
        md = m ? gd : '0;
      end else if (gr) begin
        mv = 0;
      end
      if (fv && efr) mq.push_back(!fd[W-1]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit gr);
    cyc(0, '0, 0, '0, gr, 0);
  endtask

  task automatic run_table();
    for (int i = 0; i < 4; i++)
      cyc(1, tbl[i].fd, 0, '0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, '0, 1, tbl[i].gd, 1, 0);
      chk("tbl_valid", 32'(gout_valid), 32'd1);
      chk("tbl_data", 32'(gout_data), 32'(tbl[i].exp));
    end
    idle(1);
    chk("tbl_drained", 32'(mask_count), 32'd0);
  endtask

  logic [W-1:0] held;

  initial begin
    tbl[0] = '{20'h00005, 20'h00010, 20'h00010};
    tbl[1] = '{20'hFFFFB, 20'h00010, 20'h00000};
    tbl[2] = '{20'h00000, 20'h00010, 20'h00010};
    tbl[3] = '{20'h80000, 20'h00010, 20'h00000};

    // Reset state
    #12;
    chk("rst_fwd_ready", 32'(fwd_ready), 32'd1);
    chk("rst_grad_ready", 32'(grad_ready), 32'd0);
    chk("rst_count", 32'(mask_count), 32'd0);
    chk("rst_gout_valid", 32'(gout_valid), 32'd0);
    chk("rst_gout_data", 32'(gout_data), 32'd0);
    rst_n = 1;
    @(posedge clk);
    #1;

    // Scenario 1: basic gating table
    run_table();

    // Empty FIFO: gradient must wait; push visible next cycle only
    for (int i = 0; i < 3; i++) cyc(0, '0, 1, 20'h00123, 1, 0);
    cyc(1, 20'h00001, 1, 20'h00123, 1, 0);
    chk("no_bypass_valid", 32'(gout_valid), 32'd0);
    cyc(0, '0, 1, 20'h00123, 1, 0);
    chk("after_push_valid", 32'(gout_valid), 32'd1);
    idle(1);

    // Fill to capacity, then pop with a blocked push
    for (int i = 0; i < D; i++)
      cyc(1, W'($urandom), 0, '0, 1, 0);
    chk("full_count", 32'(mask_count), 32'(D));
    chk("full_fwd_ready", 32'(fwd_ready), 32'd0);
    cyc(1, 20'h00001, 1, 20'h00777, 1, 0);
    chk("full_pop_count", 32'(mask_count), 32'(D - 1));

    // Random traffic across pointer wrap
    for (int i = 0; i < 200; i++)
      cyc($urandom_range(0, 1), W'($urandom),
          $urandom_range(0, 3) != 0, W'($urandom),
          $urandom_range(0, 3) != 0, 0);
    while (mq.size() != 0 || mv)
      cyc(0, '0, 1, W'($urandom), 1, 0);

    // Backpressure: hold output for 5 cycles
    for (int i = 0; i < 4; i++)
      cyc(1, (i == 1) ? 20'hF0000 : 20'h00100, 0, '0, 1, 0);
    cyc(0, '0, 1, 20'h0ABCD, 1, 0);
    held = gout_data;
    for (int i = 0; i < 5; i++) begin
      cyc(0, '0, 1, 20'h0DEAD, 0, 0);
      chk("bp_hold", 32'(gout_data), 32'(held));
    end
    for (int i = 0; i < 4; i++) cyc(0, '0, 1, W'(20'h01000 + i), 1, 0);
    idle(1);

    // Flush with 10 masks stored and output pending
    for (int i = 0; i < 11; i++)
      cyc(1, W'($urandom), 0, '0, 1, 0);
    cyc(0, '0, 1, 20'h00042, 0, 0);
    chk("pre_flush_count", 32'(mask_count), 32'd10);
    cyc(1, 20'h00001, 1, 20'h00099, 0, 1);
    chk("flush_count", 32'(mask_count), 32'd0);
    chk("flush_valid", 32'(gout_valid), 32'd0);
    chk("flush_fwd_ready", 32'(fwd_ready), 32'd1);
    run_table();

    // Asynchronous reset mid-stream
    cyc(1, 20'h00003, 0, '0, 1, 0);
    cyc(1, 20'h00003, 1, 20'h00055, 1, 0);
    #2;
    rst_n = 0;
    #1;
    chk("async_count", 32'(mask_count), 32'd0);
    chk("async_valid", 32'(gout_valid), 32'd0);
    chk("async_data", 32'(gout_data), 32'd0);
    chk("async_grad_ready", 32'(grad_ready), 32'd0);
    chk("async_fwd_ready", 32'(fwd_ready), 32'd1);
    model_reset();
    fwd_valid  = 0;
    grad_valid = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    run_table();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/relu_grad_gate.md
Name: relu_grad_gate

Overview:
- Backward-direction counterpart of the ReLU activation stage.
- In the forward pass it records one derivative bit per activation sample (1 = sample passed, 0 = sample clamped).
- In the backward pass it gates the incoming gradient stream with those bits, in order. Gradients whose forward sample was negative become zero.
- Sits beside the forward ReLU in each layer's datapath, between the upstream gradient source and the weight-update logic.

Parameters:
- WIDTH, 20, bit width of activation and gradient words (two's complement).
- DEPTH, 64, capacity of the mask FIFO in samples; must be a power of two, at least 2.
- AW, $clog2(DEPTH), FIFO pointer width; derived, not overridden.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of FIFO, counters and output stage.
- fwd_valid  in  1  forward sample valid.
- fwd_ready  out  1  mask FIFO can accept a sample.
- fwd_data  in  WIDTH  forward pre-activation sample; only the MSB is used.
- grad_valid  in  1  upstream gradient valid.
- grad_ready  out  1  gradient accepted this cycle.
- grad_in  in  WIDTH  upstream gradient.
- gout_valid  out  1  gated gradient valid.
- gout_ready  in  1  downstream accepts gated gradient.
- gout_data  out  WIDTH  gated gradient.
- mask_count  out  AW+1  masks currently stored (0..DEPTH).

Behaviour:
- Reset (rst_n=0, async): pointers=0, mask_count=0, gout_valid=0, gout_data=0. fwd_ready=1 and grad_ready=0 follow combinationally from the empty state.
- Mask rule: mask = ~fwd_data[WIDTH-1]. Zero and positive samples give mask=1, matching forward pass-through at x=0.
- Push: occurs when fwd_valid && fwd_ready.
  - fwd_ready = (mask_count != DEPTH). No bypass when full, even if a pop happens in the same cycle.
- Pop/accept: grad_ready = (mask_count != 0) && (!gout_valid || gout_ready).
  - A gradient transfer (grad_valid && grad_ready) pops exactly one mask.
  - There is no same-cycle forward-to-backward bypass: a mask pushed in cycle N is poppable from cycle N+1.
- Output stage: single register, latency 1 cycle from gradient accept to gout_valid.
  - gout_data = mask ? grad_in : 0, registered at the accept.
  - gout_valid clears when gout_ready && !(new accept).
  - gout_data holds its value while gout_valid && !gout_ready.
  - Full throughput: one gradient per cycle when gout_ready=1 continuously.
- Simultaneous push and pop: mask_count is unchanged. Both pointers advance modulo DEPTH, wrap silently.
- Counters: mask_count is a registered up/down counter and never exceeds DEPTH or goes below 0. Stalls are guaranteed by the ready logic, so no error flag is needed.
- flush: takes priority over push and pop in the same cycle.
  - Next cycle: pointers=0, mask_count=0, gout_valid=0.
  - The transfer in the flush cycle is discarded: the ready outputs are still asserted, but the data is dropped.
- Reset mid-operation: all stored masks and any pending output are lost. There is no recovery.
- Ordering: strictly FIFO; the k-th gradient is gated by the k-th forward sample since the last reset or flush.

Decomposition:
- Shared package: WIDTH default constant, a data word typedef logic [WIDTH-1:0], and a sign-bit/mask helper function shared with the forward ReLU.
- Sub-module: mask_fifo, a 1-bit-wide synchronous FIFO with push, pop, full, empty, count and flush.
- The top level holds the ready logic and the output register.

Test Plan:
- Reset, then push fwd_data 0x00005, 0xFFFFB, 0x00000, 0x80000; send grad_in 0x00010 x4 with gout_ready=1 -> gout_data 0x00010, 0x00000, 0x00010, 0x00000. Each output arrives 1 cycle after its accept; mask_count returns to 0.
- Gradient with empty FIFO: grad_valid=1, no pushes -> grad_ready=0, gout_valid stays 0. One push -> grad_ready=1 the following cycle, not the same cycle.
- Fill 64 masks -> fwd_ready=0 and mask_count=64. A simultaneous pop plus fwd_valid that cycle -> no push, count=63. Then 200 random push/pop cycles -> output matches a reference model across pointer wrap.
- Backpressure: gout_ready=0 for 5 cycles with gout_valid=1 -> gout_data stable and grad_ready=0. Release -> stream resumes with no loss or duplication.
- Assert flush with 10 masks stored and gout_valid=1 -> next cycle mask_count=0, gout_valid=0, fwd_ready=1. Subsequent masks are gated correctly.
- Drop rst_n asynchronously mid-stream between clock edges -> outputs take reset values immediately. After rst_n rises, the first push/pop sequence behaves as in scenario 1.
